register_file_mp: RTL

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional zero register, write-to-read
// forwarding and a sequential clear engine that also runs after reset.
module register_file_mp #(
    parameter int DATA_WIDTH_P   = 32,
    parameter int ADDR_WIDTH_P   = 5,
    parameter int DEPTH_P        = 32,
    parameter int NUM_RD_PORTS_P = 2,
    parameter int ZERO_REG_P     = 1,
    parameter int BYPASS_P       = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_RD_PORTS_P*ADDR_WIDTH_P-1:0] i_rd_addr,
    output logic [NUM_RD_PORTS_P*DATA_WIDTH_P-1:0] o_rd_data,
    input  logic [ADDR_WIDTH_P-1:0]                i_wr_addr,
    input  logic [DATA_WIDTH_P-1:0]                i_wr_data,
    input  logic                                   i_wr_enable,
    input  logic                                   i_clear,
    output logic                                   o_busy,
    output logic                                   o_clear_done
);

    typedef enum logic {
        IDLE_S  = 1'b0,
        CLEAR_S = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH_P-1:0] LAST_ADDR = ADDR_WIDTH_P'(DEPTH_P - 1);

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH_P-1:0]   cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic [DATA_WIDTH_P-1:0]   mem_q [DEPTH_P];
    logic                      wr_en_s;

    // An address is live when it maps to a real entry that is not the hardwired zero.
    function automatic logic addr_live(input logic [ADDR_WIDTH_P-1:0] a);
        logic ok;
        ok = ({1'b0, a} < (ADDR_WIDTH_P + 1)'(DEPTH_P));
        if ((ZERO_REG_P != 0) && (a == {ADDR_WIDTH_P{1'b0}})) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    assign wr_en_s      = (state_q == IDLE_S) && i_wr_enable && addr_live(i_wr_addr);
    assign o_busy       = (state_q == CLEAR_S);
    assign o_clear_done = done_q;

    // Clear-engine next state: walk the counter through every entry, then pulse done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (i_clear) begin
                    state_d = CLEAR_S;
                    cnt_d   = {ADDR_WIDTH_P{1'b0}};
                end else begin
                    state_d = IDLE_S;
                end
            end
            CLEAR_S: begin
                cnt_d = cnt_q + ADDR_WIDTH_P'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE_S;
                    done_d  = 1'b1;
                end else begin
                    state_d = CLEAR_S;
                end
            end
            default: begin
                state_d = CLEAR_S;
                cnt_d   = {ADDR_WIDTH_P{1'b0}};
            end
        endcase
    end

    // Engine state registers; reset restarts the clear from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_S;
            cnt_q   <= {ADDR_WIDTH_P{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Storage update: the clear sweep has priority over (and blocks) user writes.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == CLEAR_S)) begin
            mem_q[cnt_q] <= {DATA_WIDTH_P{1'b0}};
        end else if (!reset && wr_en_s) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS_P; p++) begin : g_rd
        logic [ADDR_WIDTH_P-1:0] ra_s;
        logic [DATA_WIDTH_P-1:0] rd_s;

        assign ra_s = i_rd_addr[p*ADDR_WIDTH_P +: ADDR_WIDTH_P];

        // Combinational read with optional forwarding of the same-cycle write.
        always_comb begin
            rd_s = {DATA_WIDTH_P{1'b0}};
            if ((state_q == IDLE_S) && addr_live(ra_s)) begin
                if ((BYPASS_P != 0) && wr_en_s && (ra_s == i_wr_addr)) begin
                    rd_s = i_wr_data;
                end else begin
                    rd_s = mem_q[ra_s];
                end
            end else begin
                rd_s = {DATA_WIDTH_P{1'b0}};
            end
        end

        assign o_rd_data[p*DATA_WIDTH_P +: DATA_WIDTH_P] = rd_s;
    end

endmodule
